// File: rtl/imm_pkg.sv
// Shared format codes, RV32/64 major opcodes and skid-buffer state encoding
// for the registered immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_Z   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate former: resolves the format (from opcode or sel)
// and builds the sign- or zero-extended XLEN immediate.
module imm_format_decode
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     ir,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e fmt_sel;
  logic unused_bits;

  // Some IR fields only matter in one decode mode; fold them so none dangle.
  assign unused_bits = ^{ir[6:0], ir[14:12], sel};

  always_comb begin
    fmt_sel = FMT_ILL;
    if (AUTO_DECODE) begin
      case (ir[6:0])
        OP_LOAD, OP_IMM, OP_JALR: fmt_sel = FMT_I;
        OP_IMM32:                 fmt_sel = (XLEN == 64) ? FMT_I : FMT_ILL;
        OP_STORE:                 fmt_sel = FMT_S;
        OP_BRANCH:                fmt_sel = FMT_B;
        OP_LUI, OP_AUIPC:         fmt_sel = FMT_U;
        OP_JAL:                   fmt_sel = FMT_J;
        OP_SYSTEM:                fmt_sel = ir[14] ? FMT_Z : FMT_I;
        default:                  fmt_sel = FMT_ILL;
      endcase
    end else if (sel <= 3'd5) begin
      fmt_sel = fmt_e'(sel);
    end
  end

  always_comb begin
    imm = '0;
    case (fmt_sel)
      FMT_I:   imm = XLEN'($signed(ir[31:20]));
      FMT_S:   imm = XLEN'($signed({ir[31:25], ir[11:7]}));
      FMT_B:   imm = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      FMT_U:   imm = XLEN'($signed({ir[31:12], 12'b0}));
      FMT_J:   imm = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      FMT_Z:   imm = XLEN'(ir[19:15]);
      default: imm = '0;
    endcase
  end

  assign fmt     = fmt_sel;
  assign illegal = (fmt_sel == FMT_ILL);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: decode on entry, two-entry skid
// buffer for full throughput under back-pressure, saturating illegal counter.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  skid_state_e state_q, state_d;
  entry_t      head_q, head_d, spare_q, spare_d, new_entry;
  logic [15:0] cnt_q, cnt_d;
  logic        in_fire, out_fire;

  imm_format_decode #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_decode (
    .ir      (in_ir),
    .sel     (in_sel),
    .imm     (new_entry.imm),
    .fmt     (new_entry.fmt),
    .illegal (new_entry.illegal)
  );
  assign new_entry.tag = in_tag;

  // Ready depends only on state (and reset), never on out_ready.
  assign in_ready  = ~rst & (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    spare_d = spare_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            spare_d = new_entry;
            state_d = ST_FULL;
          end
          2'b01:   state_d = ST_EMPTY;
          2'b11:   head_d  = new_entry;
          default: state_d = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (out_fire) begin
          head_d  = spare_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (out_fire && head_q.illegal && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      spare_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      spare_q <= spare_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;
  assign out_tag     = head_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomized plus directed bench for imm_gen_stage across four XLEN/AUTO_DECODE
// builds sharing one input stream, checked against a queue-based reference.
module tb_imm_gen_stage;

  localparam int TAG_W = 5;
  localparam int XL[4] = '{32, 64, 32, 64};
  localparam bit AD[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct packed {
    logic        ill;
    logic [2:0]  fmt;
    logic [63:0] imm;
  } ref_t;

  typedef struct packed {
    logic [3:0][63:0] imm;
    logic [3:0][2:0]  fmt;
    logic [3:0]       ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_ir;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready_w[4];
  logic             out_valid_w[4];
  logic [2:0]       fmt_w[4];
  logic             ill_w[4];
  logic [TAG_W-1:0] tag_w[4];
  logic [15:0]      cnt_w[4];
  logic [31:0]      imm0, imm2;
  logic [63:0]      imm1, imm3;
  logic [63:0]      obs_imm[4];

  exp_t             sb[$];
  logic [TAG_W-1:0] obs_tags[$];
  int               cnt_m[4];
  int               checkCount = 0;
  int               errCount = 0;
  int               acceptSeen = 0;

  always #5 clk = ~clk;

  assign obs_imm[0] = {32'b0, imm0};
  assign obs_imm[1] = imm1;
  assign obs_imm[2] = {32'b0, imm2};
  assign obs_imm[3] = imm3;

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(TAG_W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_ir(in_ir), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_imm(imm0), .out_fmt(fmt_w[0]),
    .out_illegal(ill_w[0]), .out_tag(tag_w[0]), .illegal_cnt(cnt_w[0]));

  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b0), .TAG_W(TAG_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_ir(in_ir), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_imm(imm1), .out_fmt(fmt_w[1]),
    .out_illegal(ill_w[1]), .out_tag(tag_w[1]), .illegal_cnt(cnt_w[1]));

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(TAG_W)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_ir(in_ir), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .out_imm(imm2), .out_fmt(fmt_w[2]),
    .out_illegal(ill_w[2]), .out_tag(tag_w[2]), .illegal_cnt(cnt_w[2]));

  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(TAG_W)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .in_ir(in_ir), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid_w[3]),
    .out_ready(out_ready), .out_imm(imm3), .out_fmt(fmt_w[3]),
    .out_illegal(ill_w[3]), .out_tag(tag_w[3]), .illegal_cnt(cnt_w[3]));

  // Reference immediate built from the field rules with plain integer arithmetic.
  function automatic ref_t refGen(int xlen, bit autoDec, logic [31:0] ir, logic [2:0] sel);
    ref_t   r;
    longint s;
    longint v;
    int     f;
    s = longint'($signed(ir));
    if (autoDec) begin
      case (ir[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: f = 0;
        7'b0011011: f = (xlen == 64) ? 0 : 7;
        7'b0100011: f = 1;
        7'b1100011: f = 2;
        7'b0110111, 7'b0010111: f = 3;
        7'b1101111: f = 4;
        7'b1110011: f = ir[14] ? 5 : 0;
        default:    f = 7;
      endcase
    end else begin
      f = (sel > 3'd5) ? 7 : int'(sel);
    end
    case (f)
      0: v = s >>> 20;
      1: v = (s >>> 25) * 32 + longint'(ir[11:7]);
      2: v = (s >>> 31) * 4096 + longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32
             + longint'(ir[11:8]) * 2;
      3: v = (s >>> 12) * 4096;
      4: v = (s >>> 31) * 1048576 + longint'(ir[19:12]) * 4096 + longint'(ir[20]) * 2048
             + longint'(ir[30:21]) * 2;
      5: v = longint'(ir[19:15]);
      default: v = 0;
    endcase
    r.imm = (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
    r.fmt = 3'(f);
    r.ill = (f == 7);
    return r;
  endfunction

  function automatic exp_t mkEntry();
    exp_t e;
    ref_t r;
    for (int k = 0; k < 4; k++) begin
      r = refGen(XL[k], AD[k], in_ir, in_sel);
      e.imm[k] = r.imm;
      e.fmt[k] = r.fmt;
      e.ill[k] = r.ill;
    end
    e.tag = in_tag;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [2:0] sel,
                               input logic [TAG_W-1:0] tag, input logic ordy);
    in_valid  = v;
    in_ir     = ir;
    in_sel    = sel;
    in_tag    = tag;
    out_ready = ordy;
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic cycle();
    bit   expReady;
    bit   inFire;
    bit   outFire;
    exp_t h;
    @(negedge clk);
    expReady = !rst && (sb.size() < 2);
    for (int k = 0; k < 4; k++) begin
      checkOutput("in_ready", 64'(in_ready_w[k]), 64'(expReady));
      checkOutput("out_valid", 64'(out_valid_w[k]), 64'(sb.size() > 0));
      checkOutput("illegal_cnt", 64'(cnt_w[k]), 64'(cnt_m[k]));
      if (sb.size() > 0) begin
        h = sb[0];
        checkOutput("out_imm", obs_imm[k], h.imm[k]);
        checkOutput("out_fmt", 64'(fmt_w[k]), 64'(h.fmt[k]));
        checkOutput("out_illegal", 64'(ill_w[k]), 64'(h.ill[k]));
        checkOutput("out_tag", 64'(tag_w[k]), 64'(h.tag));
      end
    end
    if (in_valid && in_ready_w[0]) acceptSeen++;
    if (out_valid_w[0] && out_ready && !rst) obs_tags.push_back(tag_w[0]);
    inFire  = in_valid && expReady;
    outFire = (sb.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    end else begin
      if (outFire) begin
        for (int k = 0; k < 4; k++)
          if (sb[0].ill[k] && cnt_m[k] < 65535) cnt_m[k]++;
        void'(sb.pop_front());
      end
      if (inFire) sb.push_back(mkEntry());
    end
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1);
    for (int i = 0; i < n; i++) cycle();
  endtask

  localparam logic [6:0] OPS[12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011,
                                      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                      7'b1101111, 7'b1110011, 7'b0000000, 7'b1111111};

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b0);
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_imm", obs_imm[k], 64'h0);
      checkOutput("rst_fmt", 64'(fmt_w[k]), 64'h0);
      checkOutput("rst_ill", 64'(ill_w[k]), 64'h0);
      checkOutput("rst_tag", 64'(tag_w[k]), 64'h0);
    end
    rst = 1'b0;

    // Auto-decode stream: J, illegal, Z
    applyStimulus(1'b1, 32'h0040006F, 3'd0, 5'd1, 1'b1);
    cycle();
    checkOutput("auto_j_imm", obs_imm[2], 64'd4);
    checkOutput("auto_j_fmt", 64'(fmt_w[2]), 64'd4);
    applyStimulus(1'b1, 32'h0000007F, 3'd0, 5'd2, 1'b1);
    cycle();
    checkOutput("auto_ill_imm", obs_imm[2], 64'd0);
    checkOutput("auto_ill_fmt", 64'(fmt_w[2]), 64'd7);
    checkOutput("auto_ill_flag", 64'(ill_w[2]), 64'd1);
    applyStimulus(1'b1, 32'h0002D073, 3'd0, 5'd3, 1'b1);
    cycle();
    checkOutput("auto_z_imm", obs_imm[2], 64'd5);
    checkOutput("auto_z_fmt", 64'(fmt_w[2]), 64'd5);
    checkOutput("auto_cnt", 64'(cnt_w[2]), 64'd1);
    idle(2);

    // Manual-select plan vectors
    applyStimulus(1'b1, 32'hFFF00003, 3'd0, 5'd4, 1'b1);
    cycle();
    checkOutput("plan_i_imm", obs_imm[0], 64'hFFFF_FFFF);
    checkOutput("plan_i_fmt", 64'(fmt_w[0]), 64'd0);
    applyStimulus(1'b1, 32'h00000293, 3'd1, 5'd5, 1'b1);
    cycle();
    checkOutput("plan_s_imm", obs_imm[0], 64'h5);
    applyStimulus(1'b1, 32'h4E00017F, 3'd2, 5'd6, 1'b1);
    cycle();
    checkOutput("plan_b_imm", obs_imm[0], 64'h4E2);
    applyStimulus(1'b1, 32'hABCDE123, 3'd3, 5'd7, 1'b1);
    cycle();
    checkOutput("plan_u32_imm", obs_imm[0], 64'hABCD_E000);
    checkOutput("plan_u64_imm", obs_imm[1], 64'hFFFF_FFFF_ABCD_E000);
    idle(2);

    // Back-pressure: four offered words, only two fit
    acceptSeen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom(), 3'(i), 5'(10 + i), 1'b0);
      cycle();
    end
    checkOutput("bp_accepts", 64'(acceptSeen), 64'd2);
    checkOutput("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
    obs_tags.delete();
    idle(4);
    checkOutput("bp_delivered", 64'(obs_tags.size()), 64'd2);
    if (obs_tags.size() == 2) begin
      checkOutput("bp_order0", 64'(obs_tags[0]), 64'd10);
      checkOutput("bp_order1", 64'(obs_tags[1]), 64'd11);
    end

    // Reset while full
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h0000007F, 3'd7, 5'(20 + i), 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 32'h0000007F, 3'd7, 5'd22, 1'b1);
    cycle();
    rst = 1'b1;
    applyStimulus(1'b1, $urandom(), 3'd0, 5'd23, 1'b1);
    cycle();
    checkOutput("rst_mid_valid", 64'(out_valid_w[0]), 64'd0);
    checkOutput("rst_mid_cnt", 64'(cnt_w[2]), 64'd0);
    rst = 1'b0;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[6:0] = OPS[$urandom_range(0, 11)];
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus($urandom_range(0, 3) != 0, r, 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
      cycle();
    end
    rst = 1'b0;
    idle(4);
    checkOutput("final_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised successor to the single-cycle immediate sign-extender. It sits between fetch/decode and execute in the pipelined core. It takes an instruction word through a valid/ready handshake, produces the XLEN-wide immediate and format code one cycle later, and flags unsupported formats. A two-entry skid buffer gives full throughput under back-pressure, and a saturating counter tracks illegal encodings.

## Interface
Parameters:
- XLEN, 32 — immediate width; legal values are 32 or 64; immediates are sign-extended to XLEN.
- AUTO_DECODE, 0 — 1: format derived from opcode (in_sel ignored); 0: format taken from in_sel.
- TAG_W, 5 — sideband tag width (e.g. ROB/rd id), carried unchanged.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — upstream word valid.
- in_ready  out  1  — stage can accept.
- in_ir  in  32  — instruction word.
- in_sel  in  3  — format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6–7 illegal.
- in_tag  in  TAG_W  — sideband.
- out_valid  out  1  — result valid.
- out_ready  in  1  — downstream accepts.
- out_imm  out  XLEN  — immediate.
- out_fmt  out  3  — resolved format code, same encoding as in_sel.
- out_illegal  out  1  — format unsupported; out_imm = 0.
- out_tag  out  TAG_W  — tag of the result.
- illegal_cnt  out  16  — saturating count of illegal results delivered.

## Operation
- Immediate formation from IR, all formats sign-extended from IR[31] to XLEN except Z:
  - I: IR[31:20].
  - S: {IR[31:25], IR[11:7]}.
  - B: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - U: {IR[31:12], 12'b0}, sign-extended above bit 31.
  - J: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - Z: zero-extended IR[19:15].
- AUTO_DECODE=1 opcode map:
  - 0000011, 0010011, 1100111 → I.
  - 0011011 → I, only when XLEN=64; otherwise illegal.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 1110011 → Z if funct3[2]=1, else I.
  - Any other opcode → illegal.
- Illegal: out_imm=0, out_fmt=7, out_illegal=1. The word still flows through and still consumes a slot.
- Skid buffer states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
- Transitions (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready):
  - EMPTY + in_fire → ONE.
  - ONE + in_fire & !out_fire → FULL.
  - ONE + out_fire & !in_fire → EMPTY.
  - ONE + both → ONE.
  - FULL + out_fire → ONE.
- Output order is strictly FIFO. Data is computed on entry and stored, never recomputed on exit.
- illegal_cnt increments on out_fire & out_illegal. It holds at 0xFFFF and cannot wrap.

## Timing
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0, state EMPTY.
- in_ready=0 during any cycle with rst=1, and 1 on the first cycle after release.
- Latency: a word accepted at edge N is presented at out_* after edge N (visible cycle N+1).
- Throughput: 1 word/cycle with out_ready held high.
- in_ready is driven from state registers only; it has no combinational path from out_ready.
- out_* stay stable while out_valid=1 & out_ready=0.
- Reset mid-operation discards both buffered entries; illegal_cnt clears.
- Simultaneous in_fire and out_fire in FULL cannot occur, because in_ready=0.

## Structure
- Package imm_pkg holds:
  - fmt codes (FMT_I..FMT_Z, FMT_ILL=7).
  - RV opcode constants.
- Sub-module imm_format_decode is combinational: IR, sel → imm, fmt, illegal, parametrised on XLEN and AUTO_DECODE.
- imm_gen_stage contains the skid buffer, state machine and counter.

## Test plan
- XLEN=32, sel=0, IR=0xFFF00003 → out_imm=0xFFFFFFFF, fmt=0, one cycle after accept.
- XLEN=32, sel=1, IR=0x00000293 → 0x00000005.
- XLEN=32, sel=2, IR=0x4E00017F → 0x000004E2 (1250).
- Sel=3, IR=0xABCDE123:
  - XLEN=32 → 0xABCDE000.
  - XLEN=64 → 0xFFFFFFFFABCDE000.
- AUTO_DECODE=1, stream 0x0040006F (J), 0x0000007F (illegal), 0x0002D073 (Z):
  - Results: imm 4 fmt 4; imm 0 fmt 7 illegal=1; imm 5 fmt 5.
  - illegal_cnt=1 after delivery.
- Back-pressure: 4 back-to-back words with out_ready=0 → in_ready drops after 2 accepts and exactly 2 words are held. Then release out_ready → all words delivered in order, no loss or duplication. Pulse rst mid-stream → out_valid=0 next cycle.
